// File: rtl/button_encoder_if.sv
// Purpose: consumer-side bus of button_encoder (captured code, multi flag, valid/ready).
// Latency: none, signal bundle only.
// Backpressure: the consumer holds ready low to keep the code presented indefinitely.
interface button_encoder_if;
    logic [1:0] a_out;
    logic       valid;
    logic       ready;
    logic       multi;

    // Encoder side drives the code and valid, samples ready
    modport master (
        output a_out,
        output valid,
        output multi,
        input  ready
    );

    // Consumer side samples the code and valid, drives ready
    modport slave (
        input  a_out,
        input  valid,
        input  multi,
        output ready
    );
endinterface

// File: rtl/button_encoder.sv
// Purpose: synchronize 4 async request lines, optionally debounce them, priority-encode and hold the code.
// Latency: 3 edges from d_in to valid, DB_CYCLES+3 edges when BUTTON_ENCODER_DEBOUNCE_EN is defined.
// Backpressure: code is held in HOLD until valid&&ready; then waits for all requests to clear before re-arming.
module button_encoder #(
    parameter int unsigned DB_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       d_in,
    button_encoder_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // Counters are 16 bits wide, so the stability window must fit in them
    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_db_cycles_range
        $error("button_encoder: DB_CYCLES must be within 2..65535");
    end

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [3:0] r_sync_meta;
    logic [3:0] r_sync;
    logic [3:0] w_s;
    logic [3:0] w_q;

    // Two-flop synchronizer per request line; first stage may go metastable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= d_in;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_s = r_sync;

    // ------------------------------------------------------------------
    // Filter: debounced copy of s, or s itself
    // ------------------------------------------------------------------
`ifdef BUTTON_ENCODER_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [3:0]  r_q;
    logic [15:0] r_db_cnt [4];

    // Per-bit stability counter: any return to the accepted level restarts the window,
    // a full window of disagreement makes the new level the accepted one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_s[i] == r_q[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_q[i]      <= w_s[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_q = r_q;
`else
    assign w_q = w_s;
`endif

    // ------------------------------------------------------------------
    // Priority encoder on the filtered vector
    // ------------------------------------------------------------------
    logic [1:0] w_code;
    logic [2:0] w_pop;
    logic       w_multi;
    logic       w_any;

    // Highest set bit wins: 1xxx->3, 01xx->2, 001x->1, 0001->0
    always_comb begin
        w_code = 2'd0;
        if (w_q[3]) begin
            w_code = 2'd3;
        end else if (w_q[2]) begin
            w_code = 2'd2;
        end else if (w_q[1]) begin
            w_code = 2'd1;
        end
    end

    assign w_pop   = {2'b00, w_q[0]} + {2'b00, w_q[1]} + {2'b00, w_q[2]} + {2'b00, w_q[3]};
    assign w_multi = (w_pop > 3'd1);
    assign w_any   = |w_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_capture;
    logic       w_accept;
    logic [1:0] r_a_out;
    logic       r_valid;
    logic       r_multi;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: capture on any request, leave HOLD on handshake, re-arm once all lines are clear
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!w_any) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output control: load the code on capture, drop valid on handshake; ready elsewhere is ignored
    always_comb begin
        w_capture = (r_state == ST_IDLE) && w_any;
        w_accept  = (r_state == ST_HOLD) && r_valid && bus.ready;
    end

    // Registered outputs so the consumer never sees encoder glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_out <= 2'd0;
            r_multi <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_a_out <= w_code;
            r_multi <= w_multi;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.a_out = r_a_out;
    assign bus.multi = r_multi;
    assign bus.valid = r_valid;

endmodule
